// File: rtl/wordline_scheduler.sv
// wordline_scheduler
// Shares one registered row decoder among NREQ requesters. A round-robin
// arbiter picks one requester per IDLE cycle (valid/ready handshake), then
// the access runs ACTIVE (one wordline high for ACT_CYCLES) followed by
// PRE (all wordlines low for PRE_CYCLES) before returning to IDLE.
//
// Optional build macro: SAME_ROW_BYPASS_EN
//   When defined, the last ACTIVE cycle also arbitrates. A winner whose row
//   matches the open row is accepted and ACTIVE restarts with the wordline
//   held high without a precharge gap. When undefined, every access goes
//   through PRE and req_ready is only asserted in IDLE.

module wordline_scheduler #(
   parameter int NREQ       = 4,
   parameter int ADDR_W     = 5,
   parameter int ACT_CYCLES = 2,
   parameter int PRE_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   output logic [NREQ-1:0]          req_ready,
   output logic [(1<<ADDR_W)-1:0]   wl,
   output logic                     busy,
   output logic [2:0]               owner
);

   localparam int NWL     = 1 << ADDR_W;
   localparam int CNT_MAX = (ACT_CYCLES > PRE_CYCLES) ? ACT_CYCLES : PRE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Counter load values: the counter runs down to zero, so a phase of
   // N cycles is loaded with N-1.
   localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(ACT_CYCLES - 1);
   localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_PRE    = 2'd2;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]        state,     state_nxt;
   logic [CNT_W-1:0]  cnt,       cnt_nxt;
   logic [PTR_W-1:0]  ptr,       ptr_nxt;
   logic [2:0]        owner_nxt;
   logic [NWL-1:0]    wl_nxt;

   // ------------------------------------------------------------------
   // Arbitration signals
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] addr_arr [NREQ];
   logic              arb_found;
   logic [PTR_W-1:0]  arb_idx;
   logic [PTR_W-1:0]  arb_ptr_adv;
   logic [ADDR_W-1:0] arb_addr;
   logic              bypass_ok;
   logic              grant_ok;
   logic              xfer;

   // Round-robin search: first valid requester at or after 'start',
   // wrapping modulo NREQ. Returns {found, index}.
   function automatic logic [PTR_W:0] rr_pick(input logic [NREQ-1:0]  vld,
                                              input logic [PTR_W-1:0] start);
      logic             found;
      logic [PTR_W-1:0] idx;
      logic [PTR_W-1:0] cand;
      int               pos;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos  = (int'(start) + k) % NREQ;
         cand = PTR_W'(pos);
         if (!found && vld[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   // One-hot grant vector for requester 'idx'.
   function automatic logic [NREQ-1:0] grant_vec(input logic [PTR_W-1:0] idx);
      logic [NREQ-1:0] g;
      g      = '0;
      g[idx] = 1'b1;
      return g;
   endfunction

   // Row decoder: row address to one-hot wordline vector.
   function automatic logic [NWL-1:0] row_decode(input logic [ADDR_W-1:0] row);
      logic [NWL-1:0] hot;
      hot      = '0;
      hot[row] = 1'b1;
      return hot;
   endfunction

   // Split the packed address bus into one row address per requester.
   for (genvar g = 0; g < NREQ; g++) begin : g_addr
      assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
   end

   // Combinational round-robin winner from the current priority pointer.
   always_comb begin
      {arb_found, arb_idx} = rr_pick(req_valid, ptr);
   end

   assign arb_addr    = addr_arr[arb_idx];
   assign arb_ptr_adv = (arb_idx == PTR_LAST) ? '0 : arb_idx + 1'b1;

`ifdef SAME_ROW_BYPASS_EN
   logic [ADDR_W-1:0] row_p1;
   logic              last_act;

   assign last_act  = (state == ST_ACTIVE) && (cnt == '0);
   assign bypass_ok = last_act && arb_found && (arb_addr == row_p1);

   // Open-row register: only compared against on the last ACTIVE cycle,
   // and always written on the accept that opens the row, so no reset.
   always_ff @(posedge clk) begin
      if (xfer) begin
         row_p1 <= arb_addr;
      end
   end
`else
   assign bypass_ok = 1'b0;
`endif

   // Ready is held low while reset is asserted so nothing can be granted
   // against a state machine that is being cleared.
   assign grant_ok  = rst_n && arb_found && ((state == ST_IDLE) || bypass_ok);
   assign req_ready = grant_ok ? grant_vec(arb_idx) : '0;
   assign xfer      = grant_ok;
   assign busy      = (state != ST_IDLE);

   // Next-state, counter, pointer, owner and wordline computation.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      wl_nxt    = wl;
      case (state)
         ST_IDLE: begin
            if (xfer) begin
               state_nxt = ST_ACTIVE;
               cnt_nxt   = ACT_LOAD;
               ptr_nxt   = arb_ptr_adv;
               owner_nxt = 3'(arb_idx);
               wl_nxt    = row_decode(arb_addr);
            end else begin
               wl_nxt    = '0;
            end
         end
         ST_ACTIVE: begin
            if (cnt != '0) begin
               cnt_nxt   = cnt - 1'b1;
            end else if (xfer) begin
               // Same-row re-accept: the open wordline stays high.
               cnt_nxt   = ACT_LOAD;
               ptr_nxt   = arb_ptr_adv;
               owner_nxt = 3'(arb_idx);
            end else begin
               state_nxt = ST_PRE;
               cnt_nxt   = PRE_LOAD;
               wl_nxt    = '0;
            end
         end
         ST_PRE: begin
            wl_nxt = '0;
            if (cnt != '0) begin
               cnt_nxt   = cnt - 1'b1;
            end else begin
               state_nxt = ST_IDLE;
               owner_nxt = '0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            owner_nxt = '0;
            wl_nxt    = '0;
         end
      endcase
   end

   // State registers; async reset clears everything and drops wordlines.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         ptr   <= '0;
         owner <= '0;
         wl    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
         wl    <= wl_nxt;
      end
   end

endmodule

// File: tb/tb_wordline_scheduler.sv
// tb_wordline_scheduler
// Directed bench for wordline_scheduler with default parameters
// (NREQ=4, ADDR_W=5, ACT_CYCLES=2, PRE_CYCLES=1). Inputs change and
// outputs are sampled on the falling clock edge.

module tb_wordline_scheduler;

   localparam int NREQ   = 4;
   localparam int ADDR_W = 5;

   logic                   clk;
   logic                   rst_n;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ-1:0]        req_ready;
   logic [31:0]            wl;
   logic                   busy;
   logic [2:0]             owner;

   int total = 0;
   int bad   = 0;

   wordline_scheduler #(
      .NREQ       (NREQ),
      .ADDR_W     (ADDR_W),
      .ACT_CYCLES (2),
      .PRE_CYCLES (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .wl        (wl),
      .busy      (busy),
      .owner     (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_addr(input int i, input int a);
      req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
   endtask

   // Called at a falling edge in IDLE with inputs already applied; walks
   // one full access (accept, 2 ACTIVE, 1 PRE) and returns at the next
   // IDLE falling edge.
   task automatic access(input string tag, input int idx, input int row, input bit drop);
      logic [31:0] hot;
      logic [31:0] gv;
      hot = 32'd1 << row;
      gv  = 32'd1 << idx;
      #1;
      chk({tag, "/ready"},     32'(req_ready), gv);
      chk({tag, "/wl_idle"},   wl, 32'h0);
      @(negedge clk);
      chk({tag, "/ready_act"}, 32'(req_ready), 32'h0);
      chk({tag, "/wl_act1"},   wl, hot);
      chk({tag, "/owner"},     32'(owner), 32'(idx));
      chk({tag, "/busy_act"},  32'(busy), 32'h1);
      if (drop) req_valid = '0;
      @(negedge clk);
      chk({tag, "/wl_act2"},   wl, hot);
      chk({tag, "/ready_lst"}, 32'(req_ready), 32'h0);
      @(negedge clk);
      chk({tag, "/wl_pre"},    wl, 32'h0);
      chk({tag, "/busy_pre"},  32'(busy), 32'h1);
      @(negedge clk);
      chk({tag, "/busy_end"},  32'(busy), 32'h0);
      chk({tag, "/owner_end"}, 32'(owner), 32'h0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      repeat (2) @(negedge clk);

      // Reset state, with a request pending that must not be granted.
      req_valid = 4'b0001;
      set_addr(0, 7);
      #1;
      chk("rst/ready", 32'(req_ready), 32'h0);
      chk("rst/wl",    wl, 32'h0);
      chk("rst/busy",  32'(busy), 32'h0);
      chk("rst/owner", 32'(owner), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request, requester 0 row 7.
      access("single", 0, 7, 1'b1);

      // No request: stays idle.
      repeat (2) @(negedge clk);
      chk("idle/busy", 32'(busy), 32'h0);
      chk("idle/wl",   wl, 32'h0);

      // Address sweep by requester 2, every row 0..31.
      for (int a = 0; a < 32; a++) begin
         req_valid = 4'b0100;
         set_addr(2, a);
         access($sformatf("sweep%0d", a), 2, a, 1'b1);
      end

      // Pointer is now 3; requester 1 wins row 31, then reset mid-ACTIVE.
      req_valid = 4'b0010;
      set_addr(1, 31);
      #1;
      chk("ar/ready", 32'(req_ready), 32'h2);
      @(negedge clk);
      chk("ar/wl_act", wl, 32'h8000_0000);
      chk("ar/busy",   32'(busy), 32'h1);
      chk("ar/owner",  32'(owner), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar/wl_rst",    wl, 32'h0);
      chk("ar/busy_rst",  32'(busy), 32'h0);
      chk("ar/owner_rst", 32'(owner), 32'h0);
      chk("ar/ready_rst", 32'(req_ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // All requesters valid: grant order 0,1,2,3,0 (pointer reset to 0).
      req_valid = 4'b1111;
      set_addr(0, 1);
      set_addr(1, 2);
      set_addr(2, 3);
      set_addr(3, 4);
      for (int g = 0; g < 5; g++) begin
         access($sformatf("rr%0d", g), g % 4, (g % 4) + 1, 1'b0);
      end

      // Pointer at 1: only 3 valid -> 3; then 1001 -> 0; then 1001 -> 3.
      req_valid = 4'b1000;
      access("wrap3", 3, 4, 1'b1);
      req_valid = 4'b1001;
      access("wrap0", 0, 1, 1'b1);
      req_valid = 4'b1001;
      access("wrap_ptr1", 3, 4, 1'b1);

`ifdef SAME_ROW_BYPASS_EN
      // Pointer at 0: requester 0 row 5, requester 1 row 5, requester 2 row 6.
      req_valid = 4'b0111;
      set_addr(0, 5);
      set_addr(1, 5);
      set_addr(2, 6);
      #1;
      chk("byp/ready0", 32'(req_ready), 32'h1);
      @(negedge clk);
      chk("byp/wl1",    wl, 32'h20);
      chk("byp/ready1", 32'(req_ready), 32'h0);
      req_valid = 4'b0110;
      @(negedge clk);
      chk("byp/wl2",    wl, 32'h20);
      chk("byp/ready2", 32'(req_ready), 32'h2);
      @(negedge clk);
      chk("byp/wl3",    wl, 32'h20);
      chk("byp/owner3", 32'(owner), 32'h1);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("byp/wl4",    wl, 32'h20);
      chk("byp/ready4", 32'(req_ready), 32'h0);
      @(negedge clk);
      chk("byp/wl_pre", wl, 32'h0);
      chk("byp/busy",   32'(busy), 32'h1);
      @(negedge clk);
      access("byp_r2", 2, 6, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
